// File: rtl/axi_revision_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_revision_ext_pkg
// Description : Register map, response codes, FSM encodings and date packing
//               shared by the revision/uptime AXI-Lite register block.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_revision_ext_pkg;

    localparam int unsigned REG_MAJOR    = 0;
    localparam int unsigned REG_MINOR    = 1;
    localparam int unsigned REG_BUILD    = 2;
    localparam int unsigned REG_RCAND    = 3;
    localparam int unsigned REG_DATE     = 4;
    localparam int unsigned REG_TYPE     = 5;
    localparam int unsigned REG_SUBTYPE  = 6;
    localparam int unsigned REG_UPTIME   = 7;
    localparam int unsigned REG_SCRATCH0 = 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

    // WAIT_AW: data already captured; WAIT_W: address already captured
    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_WAIT_AW = 2'd1,
        WR_WAIT_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_e;

    function automatic logic [31:0] pack_date(input logic [7:0]  month,
                                              input logic [7:0]  day,
                                              input logic [15:0] year);
        return {month, day, year};
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_revision_ext_uptime_counter.sv
`default_nettype none
// ============================================================================
// Module      : uptime_counter
// Description : Free-running seconds counter driven by a clock-cycle prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
module uptime_counter #(
    parameter int CLOCK_FREQ_HZ = 250000000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] seconds
);

    localparam int PRESC_W = (CLOCK_FREQ_HZ > 1) ? $clog2(CLOCK_FREQ_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLOCK_FREQ_HZ - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        seconds_q, seconds_d;

    always_comb begin
        presc_d   = presc_q + PRESC_W'(1);
        seconds_d = seconds_q;
        if (presc_q == PRESC_LAST) begin
            presc_d   = '0;
            seconds_d = seconds_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_q   <= '0;
            seconds_q <= '0;
        end else begin
            presc_q   <= presc_d;
            seconds_q <= seconds_d;
        end
    end

    assign seconds = seconds_q;

endmodule
`default_nettype wire

// File: rtl/axi_revision_ext.sv
`default_nettype none
// ============================================================================
// Module      : axi_revision_ext
// Description : AXI4-Lite slave exposing build identity, uptime seconds and a
//               bank of byte-writable scratch registers.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_revision_ext
    import axi_revision_ext_pkg::*;
#(
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_SCRATCH      = 4,
    parameter int CLOCK_FREQ_HZ    = 250000000,
    parameter int VERSION_MAJOR    = 0,
    parameter int VERSION_MINOR    = 0,
    parameter int VERSION_BUILD    = 0,
    parameter int VERSION_RCAND    = 0,
    parameter int VERSION_YEAR     = 0,
    parameter int VERSION_MONTH    = 0,
    parameter int VERSION_DAY      = 0,
    parameter int RTL_TYPE         = 0,
    parameter int RTL_SUBTYPE      = 0
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_ARESETN,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    input  logic [2:0]                    S_AXI_ARPROT,
    output logic                          S_AXI_ARREADY,
    output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    localparam int DW    = S_AXI_DATA_WIDTH;
    localparam int SW    = S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W = S_AXI_ADDR_WIDTH - 2;

    logic [31:0] uptime_s;

    uptime_counter #(
        .CLOCK_FREQ_HZ(CLOCK_FREQ_HZ)
    ) u_uptime (
        .clk    (AXI_ACLK),
        .resetn (AXI_ARESETN),
        .seconds(uptime_s)
    );

    logic [DW-1:0] scratch_q [NUM_SCRATCH];
    logic [DW-1:0] scratch_d [NUM_SCRATCH];

    // ---------------------------------------------------------------- read
    rd_state_e     rd_state_q, rd_state_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    int unsigned   rd_idx;
    logic [DW-1:0] rd_word;
    logic          rd_err;

    always_comb begin
        rd_idx  = 32'(S_AXI_ARADDR[S_AXI_ADDR_WIDTH-1:2]);
        rd_word = '0;
        rd_err  = 1'b0;
        case (rd_idx)
            REG_MAJOR:   rd_word = 32'(VERSION_MAJOR);
            REG_MINOR:   rd_word = 32'(VERSION_MINOR);
            REG_BUILD:   rd_word = 32'(VERSION_BUILD);
            REG_RCAND:   rd_word = 32'(VERSION_RCAND);
            REG_DATE:    rd_word = pack_date(8'(VERSION_MONTH), 8'(VERSION_DAY),
                                             16'(VERSION_YEAR));
            REG_TYPE:    rd_word = 32'(RTL_TYPE);
            REG_SUBTYPE: rd_word = 32'(RTL_SUBTYPE);
            REG_UPTIME:  rd_word = uptime_s;
            default: begin
                rd_err = 1'b1;
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (rd_idx == REG_SCRATCH0 + 32'(i)) begin
                        rd_word = scratch_q[i];
                        rd_err  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (S_AXI_ARVALID && arready_q) begin
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_word;
                    rresp_d    = rd_err ? SLVERR : OKAY;
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // --------------------------------------------------------------- write
    wr_state_e        wr_state_q, wr_state_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic [IDX_W-1:0] awidx_q, awidx_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]    wstrb_q, wstrb_d;
    logic             aw_hs, w_hs, have_aw, have_w, wr_commit, wr_is_scratch;
    int unsigned      wr_idx;
    logic [DW-1:0]    wr_data;
    logic [SW-1:0]    wr_strb;

    // The completing handshake's live payload is merged with whatever was
    // captured earlier so the commit happens on that same edge.
    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        awidx_d    = awidx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_commit  = 1'b0;

        aw_hs   = S_AXI_AWVALID && awready_q;
        w_hs    = S_AXI_WVALID && wready_q;
        wr_idx  = aw_hs ? 32'(S_AXI_AWADDR[S_AXI_ADDR_WIDTH-1:2]) : 32'(awidx_q);
        wr_data = w_hs ? S_AXI_WDATA : wdata_q;
        wr_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
        wr_is_scratch = (wr_idx >= REG_SCRATCH0) &&
                        (wr_idx < REG_SCRATCH0 + 32'(NUM_SCRATCH));

        if (aw_hs) begin
            awidx_d   = S_AXI_AWADDR[S_AXI_ADDR_WIDTH-1:2];
            awready_d = 1'b0;
        end
        if (w_hs) begin
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
            wready_d = 1'b0;
        end

        have_aw = aw_hs || (wr_state_q == WR_WAIT_W);
        have_w  = w_hs  || (wr_state_q == WR_WAIT_AW);

        if (wr_state_q == WR_RESP) begin
            if (S_AXI_BREADY) begin
                bvalid_d   = 1'b0;
                awready_d  = 1'b1;
                wready_d   = 1'b1;
                wr_state_d = WR_IDLE;
            end
        end else if (have_aw && have_w) begin
            wr_commit  = 1'b1;
            bvalid_d   = 1'b1;
            bresp_d    = wr_is_scratch ? OKAY : SLVERR;
            wr_state_d = WR_RESP;
        end else if (have_aw) begin
            wr_state_d = WR_WAIT_W;
        end else if (have_w) begin
            wr_state_d = WR_WAIT_AW;
        end
    end

    always_comb begin
        scratch_d = scratch_q;
        if (wr_commit) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (wr_idx == REG_SCRATCH0 + 32'(i)) begin
                    for (int b = 0; b < SW; b++) begin
                        if (wr_strb[b]) scratch_d[i][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            scratch_q  <= '{default: '0};
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            scratch_q  <= scratch_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_revision_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_revision_ext
// Description : Directed, table-driven bench for the revision/uptime block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_revision_ext;

    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] SE = 2'b10;
    localparam int WAIT_LIMIT = 20;

    logic        clk = 1'b0;
    logic        AXI_ARESETN = 1'b0;
    logic [5:0]  S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [5:0]  S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axi_revision_ext #(
        .S_AXI_DATA_WIDTH(32),
        .S_AXI_ADDR_WIDTH(6),
        .NUM_SCRATCH     (4),
        .CLOCK_FREQ_HZ   (10),
        .VERSION_MAJOR   (2),
        .VERSION_MINOR   (1),
        .VERSION_BUILD   (7),
        .VERSION_RCAND   (3),
        .VERSION_YEAR    (2024),
        .VERSION_MONTH   (4),
        .VERSION_DAY     (29),
        .RTL_TYPE        (32'h0000ABCD),
        .RTL_SUBTYPE     (32'h00001234)
    ) dut (
        .AXI_ACLK     (clk),
        .AXI_ARESETN  (AXI_ARESETN),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_AWPROT (S_AXI_AWPROT),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARPROT (S_AXI_ARPROT),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY)
    );

    typedef struct {
        bit          is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;      // cycles W precedes AW; 0 = same cycle
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_rd(input logic [5:0] a, input logic [31:0] d,
                                   input logic [1:0] r);
        vecs.push_back('{1'b0, a, 32'h0, 4'h0, 0, d, r});
    endfunction

    function automatic void add_wr(input logic [5:0] a, input logic [31:0] d,
                                   input logic [3:0] s, input int lead,
                                   input logic [1:0] r);
        vecs.push_back('{1'b1, a, d, s, lead, 32'h0, r});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d,
                           output logic [1:0] r, output logic proto_ok);
        int n = 0;
        while (!S_AXI_ARREADY && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        if (n >= WAIT_LIMIT) check("arready_timeout", 32'(S_AXI_ARREADY), 1);
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        proto_ok = !S_AXI_RVALID;
        tick();
        S_AXI_ARVALID = 1'b0;
        proto_ok = proto_ok && S_AXI_RVALID && !S_AXI_ARREADY;
        d = S_AXI_RDATA;
        r = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        proto_ok = proto_ok && !S_AXI_RVALID && S_AXI_ARREADY;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int lead,
                            output logic [1:0] br, output logic proto_ok);
        proto_ok = 1'b1;
        S_AXI_WDATA = d;
        S_AXI_WSTRB = s;
        S_AXI_AWADDR = a;
        if (lead > 0) begin
            S_AXI_WVALID = 1'b1;
            tick();
            S_AXI_WVALID = 1'b0;
            proto_ok = proto_ok && !S_AXI_WREADY && S_AXI_AWREADY && !S_AXI_BVALID;
            repeat (lead - 1) tick();
            proto_ok = proto_ok && !S_AXI_BVALID;
            S_AXI_AWVALID = 1'b1;
            tick();
            S_AXI_AWVALID = 1'b0;
        end else begin
            S_AXI_AWVALID = 1'b1;
            S_AXI_WVALID  = 1'b1;
            tick();
            S_AXI_AWVALID = 1'b0;
            S_AXI_WVALID  = 1'b0;
        end
        proto_ok = proto_ok && S_AXI_BVALID && !S_AXI_AWREADY && !S_AXI_WREADY;
        br = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        proto_ok = proto_ok && !S_AXI_BVALID && S_AXI_AWREADY && S_AXI_WREADY;
    endtask

    task automatic reset_assert();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        AXI_ARESETN   = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok;
        int          stall_bad;
        int          up_cycles[5];

        // Identity registers and date packing (2024-04-29 -> 0x041D07E8)
        add_rd(6'h00, 32'd2, OK);
        add_rd(6'h04, 32'd1, OK);
        add_rd(6'h08, 32'd7, OK);
        add_rd(6'h0C, 32'd3, OK);
        add_rd(6'h10, 32'h041D07E8, OK);
        add_rd(6'h14, 32'h0000ABCD, OK);
        add_rd(6'h18, 32'h00001234, OK);
        add_rd(6'h20, 32'h0, OK);
        // Byte-lane scratch writes, W leading AW
        add_wr(6'h20, 32'hDEADBEEF, 4'hF, 3, OK);
        add_wr(6'h20, 32'h00005500, 4'h2, 0, OK);
        add_rd(6'h20, 32'hDEAD55EF, OK);
        // Illegal writes: RO identity, unmapped, RO uptime
        add_wr(6'h04, 32'h12345678, 4'hF, 0, SE);
        add_wr(6'h3C, 32'h12345678, 4'hF, 0, SE);
        add_wr(6'h1C, 32'h12345678, 4'hF, 1, SE);
        add_rd(6'h04, 32'd1, OK);
        add_rd(6'h3C, 32'h0, SE);
        add_rd(6'h30, 32'h0, SE);
        // Null strobe, sparse strobe, unaligned address
        add_wr(6'h2C, 32'hFFFFFFFF, 4'h0, 0, OK);
        add_rd(6'h2C, 32'h0, OK);
        add_wr(6'h2C, 32'hA5A5A5A5, 4'h9, 2, OK);
        add_rd(6'h2C, 32'hA50000A5, OK);
        add_wr(6'h27, 32'h11223344, 4'hF, 0, OK);
        add_rd(6'h24, 32'h11223344, OK);

        reset_assert();
        check("rst_arready", 32'(S_AXI_ARREADY), 1);
        check("rst_awready", 32'(S_AXI_AWREADY), 1);
        check("rst_wready",  32'(S_AXI_WREADY), 1);
        check("rst_rvalid",  32'(S_AXI_RVALID), 0);
        check("rst_bvalid",  32'(S_AXI_BVALID), 0);
        check("rst_rdata",   S_AXI_RDATA, 0);
        check("rst_rresp",   32'(S_AXI_RRESP), 0);
        check("rst_bresp",   32'(S_AXI_BRESP), 0);
        AXI_ARESETN = 1'b1;
        tick();

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead, r, ok);
                check($sformatf("v%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d_wproto", i), 32'(ok), 1);
            end else begin
                do_read(vecs[i].addr, d, r, ok);
                check($sformatf("v%0d_rdata", i), d, vecs[i].exp_data);
                check($sformatf("v%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d_rproto", i), 32'(ok), 1);
            end
        end

        // Both responses back-pressured for 20 cycles
        S_AXI_ARADDR  = 6'h20;
        S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR  = 6'h28;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'hCAFEF00D;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        stall_bad = 0;
        repeat (20) begin
            if (!S_AXI_RVALID || S_AXI_RDATA !== 32'hDEAD55EF || S_AXI_RRESP !== OK ||
                S_AXI_ARREADY || !S_AXI_BVALID || S_AXI_AWREADY || S_AXI_WREADY ||
                S_AXI_BRESP !== OK)
                stall_bad++;
            tick();
        end
        check("stall_unstable_cycles", 32'(stall_bad), 0);
        S_AXI_RREADY = 1'b1;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        S_AXI_BREADY = 1'b0;
        check("stall_release", 32'({S_AXI_RVALID, S_AXI_BVALID, S_AXI_ARREADY,
                                    S_AXI_AWREADY, S_AXI_WREADY}), 32'h07);
        do_read(6'h28, d, r, ok);
        check("stall_wr_data", d, 32'hCAFEF00D);

        // Read sampled on the commit edge sees the pre-write value
        S_AXI_ARADDR  = 6'h24;
        S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR  = 6'h24;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'h99999999;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("concur_old_value", S_AXI_RDATA, 32'h11223344);
        check("concur_both_valid", 32'({S_AXI_RVALID, S_AXI_BVALID}), 32'h3);
        S_AXI_RREADY = 1'b1;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        S_AXI_BREADY = 1'b0;
        do_read(6'h24, d, r, ok);
        check("concur_new_value", d, 32'h99999999);

        // Reset with both responses pending
        S_AXI_ARADDR  = 6'h24;
        S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR  = 6'h2C;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'h77777777;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("inflight_pending", 32'({S_AXI_RVALID, S_AXI_BVALID}), 32'h3);
        AXI_ARESETN = 1'b0;
        tick();
        check("inflight_reset", 32'({S_AXI_RVALID, S_AXI_BVALID, S_AXI_ARREADY,
                                     S_AXI_AWREADY, S_AXI_WREADY}), 32'h07);
        check("inflight_rdata", S_AXI_RDATA, 0);
        AXI_ARESETN = 1'b1;
        tick();
        do_read(6'h2C, d, r, ok);
        check("post_rst_scratch3", d, 0);
        do_read(6'h24, d, r, ok);
        check("post_rst_scratch1", d, 0);
        do_read(6'h20, d, r, ok);
        check("post_rst_scratch0", d, 0);

        // Uptime at 10 Hz: value seen N cycles after reset is N/10
        up_cycles = '{0, 9, 10, 20, 35};
        foreach (up_cycles[k]) begin
            reset_assert();
            AXI_ARESETN = 1'b1;
            repeat (up_cycles[k]) tick();
            do_read(6'h1C, d, r, ok);
            check($sformatf("uptime_%0d", up_cycles[k]), d, 32'(up_cycles[k] / 10));
            check($sformatf("uptime_%0d_resp", up_cycles[k]), 32'(r), 32'(OK));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
